// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchronizer, symmetric press/release debounce
// and an optional hold-to-repeat strobe train. All outputs are registered.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 5_000_000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    typedef enum logic [1:0] {StIdle, StPressWait, StHeld, StRelWait} state_e;

    localparam logic [CNT_W-1:0] DebLimit  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] RepDelay  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RepPeriod = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] CntMax    = '1;
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
    localparam bit               RepeatEn  = (REPEAT_DELAY != 0);
    localparam bit               DebSingle = (DEBOUNCE_CYCLES == 1);

    logic s1, s2;
    state_e state_q, state_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic rep_first_q, rep_first_d;
    logic go_press, go_release;
    logic rep_fire;
    logic [CNT_W-1:0] deb_inc, rep_inc, rep_target;
    logic pressed_d, press_d, release_d, repeat_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= ~key_n;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            deb_cnt_q     <= '0;
            rep_cnt_q     <= '0;
            rep_first_q   <= 1'b1;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state_q       <= state_d;
            deb_cnt_q     <= deb_cnt_d;
            rep_cnt_q     <= rep_cnt_d;
            rep_first_q   <= rep_first_d;
            pressed       <= pressed_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            repeat_pulse  <= repeat_d;
        end
    end

    // Saturating increments; the repeat counter restarts after every strobe.
    assign deb_inc    = (deb_cnt_q == CntMax) ? deb_cnt_q : deb_cnt_q + CntOne;
    assign rep_inc    = (rep_cnt_q == CntMax) ? rep_cnt_q : rep_cnt_q + CntOne;
    assign rep_target = rep_first_q ? RepDelay : RepPeriod;
    assign rep_fire   = RepeatEn && (state_q == StHeld) && s2 && (rep_inc == rep_target);

    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        go_press    = 1'b0;
        go_release  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (s2) begin
                    if (DebSingle) begin
                        state_d     = StHeld;
                        go_press    = 1'b1;
                        rep_cnt_d   = '0;
                        rep_first_d = 1'b1;
                    end else begin
                        state_d   = StPressWait;
                        deb_cnt_d = CntOne;
                    end
                end
            end
            StPressWait: begin
                if (!s2) begin
                    state_d   = StIdle;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DebLimit) begin
                    state_d     = StHeld;
                    go_press    = 1'b1;
                    deb_cnt_d   = '0;
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_inc;
                end
            end
            StHeld: begin
                if (!s2) begin
                    if (DebSingle) begin
                        state_d    = StIdle;
                        go_release = 1'b1;
                    end else begin
                        state_d   = StRelWait;
                        deb_cnt_d = CntOne;
                    end
                end else if (rep_fire) begin
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b0;
                end else begin
                    rep_cnt_d = rep_inc;
                end
            end
            StRelWait: begin
                if (s2) begin
                    state_d   = StHeld;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DebLimit) begin
                    state_d    = StIdle;
                    go_release = 1'b1;
                    deb_cnt_d  = '0;
                end else begin
                    deb_cnt_d = deb_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        press_d   = go_press;
        release_d = go_release;
        repeat_d  = rep_fire;
        pressed_d = pressed;
        if (go_press) begin
            pressed_d = 1'b1;
        end else if (go_release) begin
            pressed_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Randomized bench for key_debounce; a run-length reference model predicts every output
// of two instances (repeat enabled and repeat disabled) on every cycle.
module tb_key_debounce;

    localparam int unsigned D    = 4;
    localparam int unsigned RD   = 10;
    localparam int unsigned P    = 3;
    localparam int unsigned NEED = (D == 1) ? 1 : D + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_n = 1'b1;
    logic pr0, pp0, rl0, rp0;
    logic pr1, pp1, rl1, rp1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_debounce #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(P), .CNT_W(8)
    ) dut0 (
        .clk(clk), .rst(rst), .key_n(key_n),
        .pressed(pr0), .press_pulse(pp0), .release_pulse(rl0), .repeat_pulse(rp0)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(0), .REPEAT_PERIOD(P), .CNT_W(8)
    ) dut1 (
        .clk(clk), .rst(rst), .key_n(key_n),
        .pressed(pr1), .press_pulse(pp1), .release_pulse(rl1), .repeat_pulse(rp1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a level change is accepted after NEED consecutive samples of the
    // synchronized key differing from the accepted level. Repeat strobes are placed by
    // counting stable-held samples since the accepted press.
    logic sy1, sy2;
    logic acc;
    int   run, hc;
    logic e_press, e_rel, e_rep;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sy1 = 0; sy2 = 0; acc = 0; run = 0; hc = 0;
            e_press = 0; e_rel = 0; e_rep = 0;
        end else begin
            logic s, prev_acc;
            int prev_run;
            s = sy2;
            prev_acc = acc;
            prev_run = run;
            e_press = 0; e_rel = 0; e_rep = 0;
            if (s != acc) begin
                run++;
                if (run == NEED) begin
                    acc = s;
                    run = 0;
                    if (acc) begin
                        e_press = 1;
                        hc = 0;
                    end else begin
                        e_rel = 1;
                    end
                end
            end else begin
                run = 0;
            end
            if (prev_acc && prev_run == 0 && s) begin
                hc++;
                if (hc == RD || (hc > RD && (hc - RD) % P == 0)) e_rep = 1;
            end
            sy2 = sy1;
            sy1 = ~key_n;
        end
    end

    always @(negedge clk) begin
        check("pressed", pr0, acc);
        check("press_pulse", pp0, e_press);
        check("release_pulse", rl0, e_rel);
        check("repeat_pulse", rp0, e_rep);
        check("mutex", 32'(pp0) + 32'(rl0) + 32'(rp0) <= 1, 1);
        check("norep_pressed", pr1, acc);
        check("norep_press", pp1, e_press);
        check("norep_release", rl1, e_rel);
        check("norep_repeat", rp1, 0);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Key goes low at the current negedge; loop index i is the negedge after edge i.
    task automatic press_latency(input int hold);
        key_n = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("lat_press", pp0, i == 6);
            check("lat_pressed", pr0, i >= 6);
            check("lat_repeat", rp0, i >= 16 && (i - 16) % 3 == 0);
        end
    endtask

    initial begin
        idle(3);
        check("rst_pressed", pr0, 0);
        check("rst_pulses", {pp0, rl0, rp0}, 0);
        rst = 1'b0;
        idle(3);

        press_latency(40);

        key_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("lat_release", rl0, i == 6);
            check("lat_rel_pressed", pr0, i < 6);
        end

        for (int k = 0; k < 5; k++) begin
            key_n = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("bounce", {pr0, pp0, rl0, rp0}, 0);
            end
            key_n = 1'b1;
            @(negedge clk);
            check("bounce", {pr0, pp0, rl0, rp0}, 0);
        end
        idle(6);

        key_n = 1'b0;
        idle(20);
        key_n = 1'b1;
        idle(2);
        key_n = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("glitch_pressed", pr0, 1);
            check("glitch_release", rl0, 0);
        end
        key_n = 1'b1;
        idle(12);

        for (int k = 0; k < 250; k++) begin
            key_n = logic'($urandom_range(0, 1));
            idle($urandom_range(1, 14));
        end
        key_n = 1'b1;
        idle(12);

        key_n = 1'b0;
        idle(4);
        #2 rst = 1'b1;
        #1 check("rst_presswait", {pr0, pp0, rl0, rp0}, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(14);
        check("pre_rst_held", pr0, 1);
        #2 rst = 1'b1;
        #1 check("rst_held", {pr0, pp0, rl0, rp0}, 0);
        check("rst_held_norep", {pr1, pp1, rl1, rp1}, 0);
        @(negedge clk);
        rst = 1'b0;
        press_latency(30);
        key_n = 1'b1;
        idle(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
